// File: rtl/balance_pkg.sv
// Shared constants and saturation helpers for the balance controller.
package balance_pkg;

  localparam logic [11:0] STEER_MIN = 12'h200;
  localparam logic [11:0] STEER_MAX = 12'hE00;
  localparam logic [11:0] STEER_CTR = 12'h7FF;
  localparam int          PTCH_CLIP = 511;
  localparam int          INTEG_W   = 18;

  function automatic logic signed [31:0] clip(input logic signed [31:0] val,
                                              input logic signed [31:0] lo,
                                              input logic signed [31:0] hi);
    logic signed [31:0] res;
    res = val;
    if (val > hi) begin
      res = hi;
    end else if (val < lo) begin
      res = lo;
    end
    return res;
  endfunction

  // Clamp to the range of a signed number of the given width.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                    input int width);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    return clip(val, -hi - 32'sd1, hi);
  endfunction

  function automatic logic signed [31:0] abs_val(input logic signed [31:0] val);
    return (val < 0) ? -val : val;
  endfunction

endpackage

// File: rtl/balance_pid_core.sv
// Stages 1-2 of the balance pipeline: sample capture, integrator and P/I/D terms,
// followed by the saturated PID sum.
module balance_pid_core
  import balance_pkg::*;
#(
  parameter int PTCH_W = 16,
  parameter int SPD_W  = 12,
  parameter int P_COEF = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [PTCH_W-1:0] ptch,
  input  logic [PTCH_W-1:0] ptch_rt,
  input  logic              pwr_up,
  input  logic              rider_off,
  output logic [SPD_W-1:0]  pid,
  output logic              pid_vld
);

  localparam int TERM_W = SPD_W + 4;

  logic                      s1_vld_q;
  logic signed [PTCH_W-1:0]  ptch_q, ptch_rt_q;
  logic signed [31:0]        ptch_sat;
  logic signed [INTEG_W-1:0] integ_q, integ_d;
  logic                      s2_vld_q;
  logic signed [TERM_W-1:0]  p_q, i_q, d_q;
  logic signed [TERM_W-1:0]  p_d, i_d, d_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      ptch_q    <= '0;
      ptch_rt_q <= '0;
    end else begin
      s1_vld_q <= vld;
      if (vld) begin
        ptch_q    <= $signed(ptch);
        ptch_rt_q <= $signed(ptch_rt);
      end
    end
  end

  assign ptch_sat = clip(32'(ptch_q), -PTCH_CLIP, PTCH_CLIP);

  // Clear dominates accumulation and holds the integrator at zero.
  always_comb begin
    integ_d = integ_q;
    if (rider_off || !pwr_up) begin
      integ_d = '0;
    end else if (s1_vld_q) begin
      integ_d = INTEG_W'(sat_signed(32'(integ_q) + ptch_sat, INTEG_W));
    end
  end

  always_comb begin
    p_d = TERM_W'(ptch_sat * P_COEF);
    i_d = TERM_W'(32'(integ_d) >>> 6);
    d_d = TERM_W'(-(32'(ptch_rt_q) >>> 6));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      integ_q  <= '0;
      p_q      <= '0;
      i_q      <= '0;
      d_q      <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      integ_q  <= integ_d;
      if (s1_vld_q) begin
        p_q <= p_d;
        i_q <= i_d;
        d_q <= d_d;
      end
    end
  end

  assign pid     = SPD_W'(sat_signed(32'(p_q) + 32'(i_q) + 32'(d_q), SPD_W));
  assign pid_vld = s2_vld_q;

endmodule

// File: rtl/balance_cntrl_pipe.sv
// Balance controller top: soft-start ramp, PID scaling, steering mix and the
// registered speed outputs.
module balance_cntrl_pipe
  import balance_pkg::*;
#(
  parameter int PTCH_W       = 16,
  parameter int SPD_W        = 12,
  parameter int P_COEF       = 9,
  parameter int TOO_FAST_THR = 1536,
  parameter int FAST_SIM     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [PTCH_W-1:0] ptch,
  input  logic [PTCH_W-1:0] ptch_rt,
  input  logic              pwr_up,
  input  logic              rider_off,
  input  logic [11:0]       steer_pot,
  input  logic              en_steer,
  output logic [SPD_W-1:0]  lft_spd,
  output logic [SPD_W-1:0]  rght_spd,
  output logic              too_fast,
  output logic              out_vld,
  output logic [7:0]        ss_tmr
);

  localparam logic [16:0] SS_STEP = (FAST_SIM != 0) ? 17'd256 : 17'd1;

  logic [15:0]             ss_cnt_q, ss_cnt_d;
  logic [16:0]             ss_sum;
  logic [SPD_W-1:0]        pid;
  logic                    pid_vld;
  logic signed [31:0]      pid_ss, steer, lft_sum, rght_sum;
  logic [11:0]             steer_clip;
  logic signed [SPD_W-1:0] lft_d, rght_d, lft_q, rght_q;
  logic                    too_fast_d, too_fast_q, out_vld_q;

  always_comb begin
    ss_sum   = {1'b0, ss_cnt_q} + SS_STEP;
    ss_cnt_d = ss_sum[16] ? 16'hFFFF : ss_sum[15:0];
    if (!pwr_up) begin
      ss_cnt_d = '0;
    end
  end

  assign ss_tmr = ss_cnt_q[15:8];

  balance_pid_core #(
    .PTCH_W (PTCH_W),
    .SPD_W  (SPD_W),
    .P_COEF (P_COEF)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .vld       (vld),
    .ptch      (ptch),
    .ptch_rt   (ptch_rt),
    .pwr_up    (pwr_up),
    .rider_off (rider_off),
    .pid       (pid),
    .pid_vld   (pid_vld)
  );

  always_comb begin
    // Arithmetic shift floors toward -inf, so small negatives stay negative.
    pid_ss = (32'($signed(pid)) * $signed({24'd0, ss_tmr})) >>> 8;

    steer_clip = steer_pot;
    if (steer_pot < STEER_MIN) begin
      steer_clip = STEER_MIN;
    end else if (steer_pot > STEER_MAX) begin
      steer_clip = STEER_MAX;
    end
    steer = (($signed({20'd0, steer_clip}) - $signed({20'd0, STEER_CTR})) * 32'sd3) >>> 4;

    lft_sum  = pid_ss;
    rght_sum = pid_ss;
    if (en_steer) begin
      lft_sum  = pid_ss + steer;
      rght_sum = pid_ss - steer;
    end
    lft_d  = SPD_W'(sat_signed(lft_sum, SPD_W));
    rght_d = SPD_W'(sat_signed(rght_sum, SPD_W));
    if (!pwr_up) begin
      lft_d  = '0;
      rght_d = '0;
    end
    too_fast_d = (abs_val(32'(lft_d)) > TOO_FAST_THR) ||
                 (abs_val(32'(rght_d)) > TOO_FAST_THR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_cnt_q   <= '0;
      lft_q      <= '0;
      rght_q     <= '0;
      too_fast_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      ss_cnt_q  <= ss_cnt_d;
      out_vld_q <= pid_vld;
      if (pid_vld) begin
        lft_q      <= lft_d;
        rght_q     <= rght_d;
        too_fast_q <= too_fast_d;
      end
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign too_fast = too_fast_q;
  assign out_vld  = out_vld_q;

endmodule

// File: tb/tb_balance_cntrl_pipe.sv
// Directed bench for balance_cntrl_pipe with hand-computed expected values.
module tb_balance_cntrl_pipe;

  logic              clk = 1'b0;
  logic              rst, vld, pwr_up, rider_off, en_steer;
  logic [15:0]       ptch, ptch_rt;
  logic [11:0]       steer_pot;
  logic signed [11:0] lft_spd, rght_spd;
  logic              too_fast, out_vld;
  logic [7:0]        ss_tmr;

  int n_cmp = 0;
  int n_err = 0;
  int vld_cnt;

  always #5 clk = ~clk;

  balance_cntrl_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .vld       (vld),
    .ptch      (ptch),
    .ptch_rt   (ptch_rt),
    .pwr_up    (pwr_up),
    .rider_off (rider_off),
    .steer_pot (steer_pot),
    .en_steer  (en_steer),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .too_fast  (too_fast),
    .out_vld   (out_vld),
    .ss_tmr    (ss_tmr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One vld pulse; checks the result appears exactly three edges later.
  task automatic send(input logic [15:0] p, input logic [15:0] pr);
    ptch    = p;
    ptch_rt = pr;
    vld     = 1'b1;
    tick;
    vld = 1'b0;
    tick;
    chk("lat_early", 32'(out_vld), 0);
    tick;
    chk("lat", 32'(out_vld), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vld = 1'b0; ptch = '0; ptch_rt = '0; pwr_up = 1'b0;
    rider_off = 1'b0; steer_pot = 12'h7FF; en_steer = 1'b0;
    repeat (3) tick;
    chk("rst_lft", 32'(lft_spd), 0);
    chk("rst_rght", 32'(rght_spd), 0);
    chk("rst_vld", 32'(out_vld), 0);
    chk("rst_tf", 32'(too_fast), 0);
    chk("rst_ss", 32'(ss_tmr), 0);
    rst = 1'b0;

    // Powered down: result still flagged valid, but zero
    send(16'd100, 16'd0);
    chk("t1_lft", 32'(lft_spd), 0);
    chk("t1_rght", 32'(rght_spd), 0);
    chk("t1_tf", 32'(too_fast), 0);
    chk("t1_ss", 32'(ss_tmr), 0);

    pwr_up = 1'b1;
    tick;
    chk("ss_step", 32'(ss_tmr), 1);
    repeat (255) tick;
    chk("ss_full", 32'(ss_tmr), 255);

    // P=144, I=0 -> 144*255>>8 = 143
    send(16'd16, 16'd0);
    chk("t2_lft", 32'(lft_spd), 143);
    chk("t2_rght", 32'(rght_spd), 143);
    chk("t2_tf", 32'(too_fast), 0);

    // steer = ((0xC00-0x7FF)*3)>>>4 = 192
    en_steer = 1'b1; steer_pot = 12'hC00;
    send(16'd16, 16'd0);
    chk("t3_lft", 32'(lft_spd), 335);
    chk("t3_rght", 32'(rght_spd), -49);
    tick;
    tick;
    chk("hold_vld", 32'(out_vld), 0);
    chk("hold_lft", 32'(lft_spd), 335);

    // -144*255 = -36720, floor(/256) = -144
    en_steer = 1'b0;
    send(16'hFFF0, 16'd0);
    chk("neg_lft", 32'(lft_spd), -144);
    chk("neg_rght", 32'(rght_spd), -144);

    // D = -(640>>>6) = -10; -10*255>>>8 = -10
    send(16'd0, 16'd640);
    chk("drt_lft", 32'(lft_spd), -10);

    // ptch clipped to 511, P=4599 -> PID 2047 -> 2039
    send(16'h7FFF, 16'd0);
    chk("t4_lft", 32'(lft_spd), 2039);
    chk("t4_rght", 32'(rght_spd), 2039);
    chk("t4_tf", 32'(too_fast), 1);

    rider_off = 1'b1;
    send(16'd0, 16'd0);
    chk("t4b_lft", 32'(lft_spd), 0);
    chk("t4b_tf", 32'(too_fast), 0);

    // Steering pot clipped at both ends: +/-288
    en_steer = 1'b1; steer_pot = 12'hFFF;
    send(16'd0, 16'd0);
    chk("sthi_lft", 32'(lft_spd), 288);
    chk("sthi_rght", 32'(rght_spd), -288);
    steer_pot = 12'h000;
    send(16'd0, 16'd0);
    chk("stlo_lft", 32'(lft_spd), -288);
    chk("stlo_rght", 32'(rght_spd), 288);
    en_steer = 1'b0; rider_off = 1'b0;

    // 300 back-to-back samples of 511: integrator saturates at 131071
    vld_cnt = 0;
    ptch = 16'd511; ptch_rt = 16'd0; vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (out_vld) vld_cnt++;
    end
    vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (out_vld) vld_cnt++;
    end
    chk("stream_cnt", vld_cnt, 300);
    chk("stream_lft", 32'(lft_spd), 2039);
    chk("stream_tf", 32'(too_fast), 1);
    chk("stream_ss", 32'(ss_tmr), 255);

    // integ 131070 -> I=2047, P=-9 -> PID 2038 -> 2030
    send(16'hFFFF, 16'd0);
    chk("isat_lft", 32'(lft_spd), 2030);
    chk("isat_rght", 32'(rght_spd), 2030);

    // Reset one cycle after vld flushes the sample
    ptch = 16'd16; vld = 1'b1;
    tick;
    vld = 1'b0; rst = 1'b1;
    tick;
    chk("t6_lft", 32'(lft_spd), 0);
    chk("t6_rght", 32'(rght_spd), 0);
    chk("t6_vld", 32'(out_vld), 0);
    chk("t6_tf", 32'(too_fast), 0);
    rst = 1'b0; pwr_up = 1'b0;
    tick;
    chk("t6_novld0", 32'(out_vld), 0);
    tick;
    chk("t6_novld1", 32'(out_vld), 0);

    // ss_tmr=22 at the output edge: 901*22>>8 = 77
    pwr_up = 1'b1;
    repeat (20) tick;
    chk("ramp_ss", 32'(ss_tmr), 20);
    send(16'd100, 16'd0);
    chk("ramp_lft", 32'(lft_spd), 77);
    chk("ramp_rght", 32'(rght_spd), 77);

    // pwr_up drops while the sample is in flight
    ptch = 16'd100; vld = 1'b1;
    tick;
    vld = 1'b0; pwr_up = 1'b0;
    tick;
    tick;
    chk("pd_vld", 32'(out_vld), 1);
    chk("pd_lft", 32'(lft_spd), 0);
    chk("pd_rght", 32'(rght_spd), 0);
    chk("pd_tf", 32'(too_fast), 0);
    chk("pd_ss", 32'(ss_tmr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/balance_cntrl_pipe.md
Name: balance_cntrl_pipe

Overview:
Parametrised next-generation balance controller for the Segway datapath. It captures pitch and pitch-rate samples on `vld` and runs a registered PID through a 3-stage pipeline. The result is scaled by a soft-start ramp, then mixed with steering to produce left and right wheel speed commands. It sits between the inertial interface and the motor-drive/PWM blocks, and adds a sample-valid output, full saturation and correct capture of `ptch_rt`.

Parameters:
PTCH_W, 16, width of signed ptch / ptch_rt inputs
SPD_W, 12, width of signed speed outputs and of the PID result
P_COEF, 9, proportional gain (unsigned multiplier)
TOO_FAST_THR, 1536, magnitude above which too_fast asserts
FAST_SIM, 1, 1: soft-start counter steps by 256 per cycle; 0: steps by 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
vld  in  1  new ptch/ptch_rt sample present this cycle
ptch  in  PTCH_W  signed pitch
ptch_rt  in  PTCH_W  signed pitch rate
pwr_up  in  1  rider enabled power
rider_off  in  1  rider absent; clears integrator
steer_pot  in  12  unsigned steering pot, centre 0x7FF
en_steer  in  1  steering enable
lft_spd  out  SPD_W  signed left speed command
rght_spd  out  SPD_W  signed right speed command
too_fast  out  1  either speed magnitude exceeds TOO_FAST_THR
out_vld  out  1  one-cycle pulse: new speed pair valid
ss_tmr  out  8  soft-start level, 0..255

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous, active-high. On reset, all registers, outputs, integrator and soft-start counter go to 0, and pipeline valids are cleared. `vld` during `rst` is ignored.
- Soft start:
  - 16-bit counter; `ss_tmr` = counter[15:8].
  - While `pwr_up`=1, the counter increments each clk by 256 (FAST_SIM=1) or 1 (FAST_SIM=0) and saturates at 0xFFFF.
  - While `pwr_up`=0, the counter is cleared synchronously.
- Stage 1 (cycle after `vld`):
  - Register `ptch` and `ptch_rt`.
  - `ptch_sat` = `ptch` clipped to the 10-bit signed range ±511.
- Stage 2:
  - Integrator is 18-bit signed, += sign-extended `ptch_sat`, saturating at +131071 / -131072.
  - Integrator is cleared (and held at 0) whenever `rider_off`=1 or `pwr_up`=0. This clear has priority over accumulation.
  - P = `ptch_sat` × P_COEF.
  - I = integrator (including the current sample) >>> 6.
  - D = -(`ptch_rt` >>> 6).
  - All terms are sign-extended to SPD_W+4 bits.
- Stage 3:
  - PID = P+I+D, saturated to SPD_W signed.
  - PID_ss = (PID × `ss_tmr`) >>> 8, an arithmetic shift that floors toward -inf.
  - When `en_steer`=1:
    - steer_clip = `steer_pot` clipped to 0x200..0xE00.
    - steer = ((steer_clip − 0x7FF) × 3) >>> 4.
    - `lft_spd` = sat(PID_ss + steer), `rght_spd` = sat(PID_ss − steer), saturated to SPD_W signed.
  - When `en_steer`=0, both outputs = PID_ss.
  - When `pwr_up`=0, both outputs are forced to 0.
  - `too_fast` = |`lft_spd`|>TOO_FAST_THR or |`rght_spd`|>TOO_FAST_THR.
  - `lft_spd`, `rght_spd`, `too_fast` and `out_vld` are all registered together.
- Latency and hold:
  - `out_vld` pulses exactly 3 clk after a `vld` cycle.
  - Back-to-back `vld` is supported at full rate, one result per cycle.
  - Between pulses, the outputs hold their last value.
- `pwr_up` falling mid-pipeline: the integrator and counter clear on the next edge. Any result emitted while `pwr_up`=0 is 0 and `too_fast`=0.
- `rst` mid-operation flushes in-flight samples; no `out_vld` is generated for them.
- Steering, `pwr_up` and `rider_off` are sampled at the stage where they are used (no alignment registers).

Decomposition:
- Package `balance_pkg`:
  - Constants STEER_MIN=0x200, STEER_MAX=0xE00, STEER_CTR=0x7FF, PTCH_CLIP=511, INTEG_W=18.
  - Parametrised saturate function.
- One sub-module `balance_pid_core`: stages 1–2 plus the PID sum with saturation, producing PID and a valid.
- The top level holds the soft-start counter, scaling, steering mix and `too_fast`.

Test Plan:
1. Reset then release, `pwr_up`=0, pulse `vld` → `out_vld` 3 cycles later, `lft_spd`=`rght_spd`=0, `too_fast`=0, `ss_tmr`=0.
2. FAST_SIM=1, `pwr_up`=1 for 256 clk, then `vld` with `ptch`=16, `ptch_rt`=0, `en_steer`=0, integrator 0 → `ss_tmr`=255, `lft_spd`=`rght_spd`=143.
3. Same as 2 with `en_steer`=1, `steer_pot`=0xC00 → `lft_spd`=335, `rght_spd`=−49.
4. `ss_tmr`=255, `ptch`=0x7FFF → PID saturates to 2047, outputs 2039, `too_fast`=1. Then `ptch`=0 with `rider_off`=1 (integrator cleared) → `too_fast`=0.
5. 300 consecutive `vld` with `ptch`=511 → integrator saturates at 131071; I term = 2047; no wrap; `out_vld` every cycle.
6. `rst` asserted one cycle after `vld` → no `out_vld`; all outputs 0 on the following edge.
